// File: rtl/sda_link_if.sv
// Requester-side handshake bundle for sda_link_ctrl: command in, response out.
// Command: accepted on a rising edge where tx_valid && tx_ready; tx_data is sampled on that edge.
//   Response: rx_valid is a one-cycle pulse qualifying rx_data/rx_perr, and there is no backpressure.
interface sda_link_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_perr;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, rx_perr
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, rx_perr
  );
endinterface

// File: rtl/sda_link_ctrl.sv
// Master-side sequencer for the half-duplex sda link: send word, release line, receive word.
// Optional even parity in both directions is enabled by defining LINK_PARITY_EN.
module sda_link_ctrl #(
  parameter int DATA_W   = 8,
  parameter int TURN_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  sda_link_if.slave  link,
  output logic       busy,
  output logic       sda_out,
  output logic       sda_oe,
  input  logic       sda_in,
  output logic [1:0] state_dbg
);

`ifdef LINK_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] TURN = 2'd2;
  localparam logic [1:0] RECV = 2'd3;

  localparam logic [5:0] LAST_BIT  = 6'(NBITS - 1);
  localparam logic [5:0] TURN_LAST = 6'(TURN_CYC - 1);

  logic [1:0]        state;
  logic [5:0]        cnt;
  logic [NBITS-1:0]  tx_shift;
  logic [NBITS-1:0]  rx_shift;
  logic [NBITS-1:0]  tx_load;
  logic [NBITS-1:0]  rx_word;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;

`ifdef LINK_PARITY_EN
  logic rx_perr_q;
  assign tx_load      = {link.tx_data, ^link.tx_data};
  assign link.rx_perr = rx_perr_q;
`else
  assign tx_load      = link.tx_data;
  assign link.rx_perr = 1'b0;
`endif

  // Word as it stands once the current sda_in sample is shifted in.
  assign rx_word = {rx_shift[NBITS-2:0], sda_in};

  assign link.tx_ready = (state == IDLE);
  assign link.rx_data  = rx_data_q;
  assign link.rx_valid = rx_valid_q;
  assign state_dbg     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy       <= 1'b0;
      sda_out    <= 1'b0;
      sda_oe     <= 1'b0;
`ifdef LINK_PARITY_EN
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      rx_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (link.tx_valid) begin
            // tx_shift holds the bits still to be driven, next one at the MSB.
            tx_shift <= tx_load << 1;
            sda_out  <= tx_load[NBITS-1];
            sda_oe   <= 1'b1;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (cnt == LAST_BIT) begin
            sda_oe <= 1'b0;
            cnt    <= '0;
            state  <= TURN;
          end else begin
            cnt      <= cnt + 6'd1;
            sda_out  <= tx_shift[NBITS-1];
            tx_shift <= tx_shift << 1;
          end
        end
        TURN: begin
          if (cnt == TURN_LAST) begin
            cnt   <= '0;
            state <= RECV;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        RECV: begin
          rx_shift <= rx_word;
          if (cnt == LAST_BIT) begin
            rx_data_q  <= rx_word[NBITS-1 -: DATA_W];
            rx_valid_q <= 1'b1;
`ifdef LINK_PARITY_EN
            // Even parity: XOR over data plus parity bit must be zero.
            rx_perr_q  <= ^rx_word;
`endif
            cnt        <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sda_link_ctrl.sv
// Directed bench for sda_link_ctrl: one instance at TURN_CYC=1, one at TURN_CYC=3,
// with the peer response driven bit by bit on sda_in.
module tb_sda_link_ctrl;

`ifdef LINK_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sel = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       sda_in = 1'b1;

  logic busy1, out1, oe1, busy3, out3, oe3;
  logic [1:0] st1, st3;

  sda_link_if #(.DATA_W(8)) if1 ();
  sda_link_if #(.DATA_W(8)) if3 ();

  assign if1.tx_data  = tx_data;
  assign if1.tx_valid = tx_valid & ~sel;
  assign if3.tx_data  = tx_data;
  assign if3.tx_valid = tx_valid & sel;

  sda_link_ctrl #(.DATA_W(8), .TURN_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .link(if1), .busy(busy1),
    .sda_out(out1), .sda_oe(oe1), .sda_in(sda_in), .state_dbg(st1)
  );

  sda_link_ctrl #(.DATA_W(8), .TURN_CYC(3)) dut3 (
    .clk(clk), .rst(rst), .link(if3), .busy(busy3),
    .sda_out(out3), .sda_oe(oe3), .sda_in(sda_in), .state_dbg(st3)
  );

  logic       o_oe, o_out, o_rdy, o_busy, o_rv, o_perr;
  logic [7:0] o_rd;
  always_comb begin
    o_oe   = sel ? oe3 : oe1;
    o_out  = sel ? out3 : out1;
    o_rdy  = sel ? if3.tx_ready : if1.tx_ready;
    o_busy = sel ? busy3 : busy1;
    o_rv   = sel ? if3.rx_valid : if1.rx_valid;
    o_perr = sel ? if3.rx_perr : if1.rx_perr;
    o_rd   = sel ? if3.rx_data : if1.rx_data;
  end

  // scoreboard
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: one full transaction on the selected instance; with hold set,
  // tx_valid stays high carrying next_tx so the following call accepts with no gap
  task automatic txn(input logic [7:0] tx, input logic [7:0] peer, input logic ppar,
                     input bit hold, input logic [7:0] next_tx);
    int t;
    logic [NB-1:0] sent;
    logic [NB-1:0] reply;
    logic exp_perr;
    logic [7:0] exp_rx;
    t = sel ? 3 : 1;
`ifdef LINK_PARITY_EN
    sent     = {tx, ^tx};
    reply    = {peer, ppar};
    exp_perr = (^peer) != ppar;
`else
    sent     = tx;
    reply    = peer;
    exp_perr = 1'b0;
`endif
    exp_q.push_back(peer);
    tx_data  = tx;
    tx_valid = 1'b1;
    sda_in   = 1'b1;
    step();
    check("accept_ready_low", o_rdy, 0);
    check("accept_busy", o_busy, 1);
    if (hold) tx_data = next_tx;
    else tx_valid = 1'b0;
    for (int k = 0; k < NB; k++) begin
      check("send_oe", o_oe, 1);
      check("send_bit", o_out, sent[NB-1-k]);
      step();
    end
    for (int i = 0; i < t; i++) begin
      check("turn_oe", o_oe, 0);
      check("turn_rv", o_rv, 0);
      step();
    end
    for (int j = 0; j < NB; j++) begin
      sda_in = reply[NB-1-j];
      check("recv_oe", o_oe, 0);
      check("recv_rv_early", o_rv, 0);
      check("recv_ready_low", o_rdy, 0);
      step();
    end
    sda_in = 1'b1;
    check("rx_valid", o_rv, 1);
    check("rx_busy_low", o_busy, 0);
    check("rx_ready", o_rdy, 1);
    check("rx_oe", o_oe, 0);
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      exp_rx = exp_q.pop_front();
      check("rx_data", o_rd, exp_rx);
    end
    check("rx_perr", o_perr, exp_perr);
    if (!hold) begin
      step();
      check("rx_valid_pulse", o_rv, 0);
      check("idle_busy", o_busy, 0);
    end
  endtask

  initial begin
    int rv_seen;
    // reset state
    rst = 1'b1;
    step(); step(); step();
    check("rst_ready", if1.tx_ready, 1);
    check("rst_busy", busy1, 0);
    check("rst_oe", oe1, 0);
    check("rst_out", out1, 0);
    check("rst_rv", if1.rx_valid, 0);
    check("rst_rd", if1.rx_data, 0);
    check("rst_perr", if1.rx_perr, 0);
    check("rst_state", st1, 0);
    check("rst3_oe", oe3, 0);
    rst = 1'b0;
    step();

    // single transaction, then response with wrong parity
    txn(8'h9D, 8'h5A, 1'b0, 1'b0, 8'h00);
    txn(8'h9D, 8'h5A, 1'b1, 1'b0, 8'h00);

    // back-to-back with tx_valid held
    txn(8'h9D, 8'h5A, 1'b0, 1'b1, 8'hC3);
    txn(8'hC3, 8'h24, 1'b1, 1'b0, 8'h00);

    // reset during the 4th SEND cycle
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    step(); step(); step();
    check("mid_oe_before", oe1, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_oe", oe1, 0);
    check("mid_ready", if1.tx_ready, 1);
    check("mid_busy", busy1, 0);
    check("mid_rv", if1.rx_valid, 0);
    check("mid_rd", if1.rx_data, 0);
    rv_seen = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (if1.rx_valid || oe1) rv_seen++;
    end
    check("mid_quiet", rv_seen, 0);
    txn(8'hFF, 8'h3C, 1'b0, 1'b0, 8'h00);

    // TURN_CYC=3 instance
    sel = 1'b1;
    step();
    txn(8'h9D, 8'h5A, 1'b1, 1'b0, 8'h00);
    txn(8'h01, 8'h80, 1'b1, 1'b0, 8'h00);
    sel = 1'b0;

    // report
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sda_link_ctrl.md
Name: sda_link_ctrl

Overview:
Master-side sequencer for the single-wire half-duplex serial link (sda line plus direction select).
- Accepts a command word from a requester.
- Drives the word onto the line MSB first, releases the line for a turnaround gap, then samples the peer's response word MSB first.
- Returns the response with a one-cycle valid pulse.
- Owns the direction control, so the requester never touches the line directly. The top level builds the tri-state from sda_out and sda_oe.

Parameters:
DATA_W, 8, bits per word in each direction (2..32)
TURN_CYC, 1, released-line turnaround cycles between send and receive (1..15)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
tx_data  input  DATA_W  command word, sampled on accept
tx_valid  input  1  requester has a command
tx_ready  output  1  controller can accept (high only in IDLE)
rx_data  output  DATA_W  received response word, held until the next response
rx_valid  output  1  one-cycle pulse, rx_data (and rx_perr) valid
rx_perr  output  1  parity error flag, qualified by rx_valid
busy  output  1  high in any state other than IDLE
sda_out  output  1  line value driven by the controller
sda_oe  output  1  1 = controller drives line, 0 = line released
sda_in  input  1  sampled line value

Behaviour:
- States: IDLE, SEND, TURN, RECV. All outputs are registered.
- Reset values: state IDLE, sda_oe 0, sda_out 0, rx_data 0, rx_valid 0, rx_perr 0, busy 0, bit counter 0.
- tx_ready is combinational (state == IDLE).
- Reset mid-transaction: line released at the next edge, partial data discarded, no rx_valid.

IDLE:
- Accept when tx_valid && tx_ready.
- At the accepting edge: shift register <= tx_data, sda_oe <= 1, sda_out <= tx_data[DATA_W-1], counter <= 0, state <= SEND.

SEND:
- One bit per cycle, MSB first. Bit k is on the line during the k-th cycle after accept.
- At each edge, if counter == NBITS-1: sda_oe <= 0, counter <= 0, state <= TURN.
- Otherwise: counter++, sda_out <= next bit.
- NBITS = DATA_W, or DATA_W+1 with parity.

TURN:
- sda_oe = 0 for exactly TURN_CYC cycles, then state <= RECV.
- sda_out holds its last value; it is ignored while released.

RECV:
- At each edge: rx shift <= {rx shift, sda_in} (first sampled bit ends up as the MSB).
- After NBITS samples: rx_data <= assembled word, rx_valid <= 1 for one cycle, state <= IDLE.
- No line sampling occurs outside RECV.

Latency and overlap:
- Defaults: accept at edge E0 → sda_oe high E0..E8 → released from E8 → samples at E10..E17 → rx_valid high E17..E18.
- General form: rx_valid rises DATA_W+TURN_CYC+DATA_W edges after accept.
- A new command may be accepted in the same cycle rx_valid is high, since the state is already IDLE.
- tx_valid held continuously → back-to-back transactions with no idle gap.

Direction rule: sda_oe is never 1 outside SEND. The controller never drives during TURN or RECV.

Optional Feature:
Macro LINK_PARITY_EN.
- Defined:
  - SEND appends one even-parity bit (XOR of tx_data) after the LSB, with sda_oe still 1.
  - RECV samples DATA_W+1 bits; the last is parity.
  - rx_perr = (XOR of received data) != received parity bit, asserted with rx_valid.
  - Latency grows by 2 cycles.
- Undefined:
  - No parity bit in either direction.
  - rx_perr is tied 0 (port still present).

Test Plan:
- Reset, then tx_data=0x9D with tx_valid pulsed one cycle → sda_out sequence 1,0,0,1,1,1,0,1 with sda_oe=1 for exactly 8 cycles, then sda_oe=0; tx_ready low until return to IDLE.
- Peer bench drives 0x5A MSB first during RECV cycles → rx_valid single pulse 17 cycles after accept, rx_data=0x5A, busy drops in the same cycle.
- tx_valid held high with 0x9D then 0xC3 → second accept coincides with the first rx_valid; second send starts the next cycle with no gap.
- rst asserted during the 4th SEND cycle → sda_oe=0 at the next edge, no rx_valid, tx_ready=1; a fresh 0xFF transaction then completes normally.
- TURN_CYC=3 → sda_oe low for 3 cycles before the first sample; rx_valid 19 cycles after accept.
- LINK_PARITY_EN, send 0x9D → 9th driven bit 1. Peer replies 0x5A with parity 0 → rx_perr=0; peer replies 0x5A with parity 1 → rx_perr=1.
